// File: rtl/fifo_ctrl.sv
// fifo_ctrl: sequential control and storage stage of an 8-entry FIFO.
// It registers write/read requests into an operation state, owns the
// head/tail/data_count registers and the word storage, and drives dout and
// the status flags. A request is judged against the count that will exist
// once the operation already held in the state register has completed.
// Optional feature: define FIFO_CTRL_ALMOST_EN to add almost_full and
// almost_empty outputs.
module fifo_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [3:0]            data_count,
    output logic                  full,
    output logic                  empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err
`ifdef FIFO_CTRL_ALMOST_EN
    ,
    output logic                  almost_full,
    output logic                  almost_empty
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_WRITE    = 3'b001,
        ST_READ     = 3'b010,
        ST_WR_ERROR = 3'b011,
        ST_RD_ERROR = 3'b100
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [2:0]              head_r;
    logic [2:0]              tail_r;
    logic [3:0]              data_count_r;
    logic [2:0]              next_head_s;
    logic [2:0]              next_tail_s;
    logic [3:0]              next_count_s;
    logic [DATA_WIDTH-1:0]   din_q_r;
    logic [DATA_WIDTH-1:0]   dout_r;
    logic                    wr_ack_r;
    logic                    wr_err_r;
    logic                    rd_ack_r;
    logic                    rd_err_r;
    logic [DATA_WIDTH-1:0]   mem_r [0:7];

    // Next pointer/count values once the operation held in state_r completes.
    always_comb begin
        next_head_s  = head_r;
        next_tail_s  = tail_r;
        next_count_s = data_count_r;
        case (state_r)
            ST_WRITE: begin
                next_tail_s  = tail_r + 3'd1;
                next_count_s = data_count_r + 4'd1;
            end
            ST_READ: begin
                next_head_s  = head_r + 3'd1;
                next_count_s = data_count_r - 4'd1;
            end
            default: begin
                next_head_s  = head_r;
                next_tail_s  = tail_r;
                next_count_s = data_count_r;
            end
        endcase
    end

    // Request decode: a lone request is checked against the post-operation count.
    always_comb begin
        state_next_s = ST_IDLE;
        if (wr_en && !rd_en) begin
            if (next_count_s == 4'd8) begin
                state_next_s = ST_WR_ERROR;
            end else begin
                state_next_s = ST_WRITE;
            end
        end else if (rd_en && !wr_en) begin
            if (next_count_s == 4'd0) begin
                state_next_s = ST_RD_ERROR;
            end else begin
                state_next_s = ST_READ;
            end
        end else begin
            state_next_s = ST_IDLE;
        end
    end

    // Operation state register with its registered ack/err outputs; illegal codes recover to IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            wr_ack_r <= 1'b0;
            wr_err_r <= 1'b0;
            rd_ack_r <= 1'b0;
            rd_err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_WRITE, ST_READ, ST_WR_ERROR, ST_RD_ERROR: begin
                    state_r  <= state_next_s;
                    wr_ack_r <= (state_next_s == ST_WRITE);
                    wr_err_r <= (state_next_s == ST_WR_ERROR);
                    rd_ack_r <= (state_next_s == ST_READ);
                    rd_err_r <= (state_next_s == ST_RD_ERROR);
                end
                default: begin
                    state_r  <= ST_IDLE;
                    wr_ack_r <= 1'b0;
                    wr_err_r <= 1'b0;
                    rd_ack_r <= 1'b0;
                    rd_err_r <= 1'b0;
                end
            endcase
        end
    end

    // Pointers, count, read data and the captured write word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_r       <= 3'd0;
            tail_r       <= 3'd0;
            data_count_r <= 4'd0;
            dout_r       <= {DATA_WIDTH{1'b0}};
            din_q_r      <= {DATA_WIDTH{1'b0}};
        end else begin
            head_r       <= next_head_s;
            tail_r       <= next_tail_s;
            data_count_r <= next_count_s;
            if (state_r == ST_READ) begin
                dout_r <= mem_r[head_r];
            end
            if (state_next_s == ST_WRITE) begin
                din_q_r <= din;
            end
        end
    end

    // Word storage: written only while a WRITE completes, never reset.
    always_ff @(posedge clk) begin
        if (state_r == ST_WRITE) begin
            mem_r[tail_r] <= din_q_r;
        end
    end

    assign dout       = dout_r;
    assign data_count = data_count_r;
    assign full       = (data_count_r == 4'd8);
    assign empty      = (data_count_r == 4'd0);
    assign wr_ack     = wr_ack_r;
    assign wr_err     = wr_err_r;
    assign rd_ack     = rd_ack_r;
    assign rd_err     = rd_err_r;

`ifdef FIFO_CTRL_ALMOST_EN
    assign almost_full  = (data_count_r == 4'd7);
    assign almost_empty = (data_count_r == 4'd1);
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl. The driver keeps a queue-based model of
// the FIFO contents and pushes the expected ack/err event (with the dout value
// expected after it) into a scoreboard; a monitor pops and compares whenever
// the DUT raises an ack or err.
module tb_fifo_ctrl;

    localparam logic [3:0] EV_WACK = 4'b1000;
    localparam logic [3:0] EV_WERR = 4'b0100;
    localparam logic [3:0] EV_RACK = 4'b0010;
    localparam logic [3:0] EV_RERR = 4'b0001;

    typedef struct {
        logic [3:0]  flags;
        logic [31:0] dout;
    } ev_t;

    logic        clk;
    logic        reset_n;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] din;
    logic [31:0] dout;
    logic [3:0]  data_count;
    logic        full;
    logic        empty;
    logic        wr_ack;
    logic        wr_err;
    logic        rd_ack;
    logic        rd_err;
`ifdef FIFO_CTRL_ALMOST_EN
    logic        almost_full;
    logic        almost_empty;
`endif

    int          tests_run;
    int          tests_failed;
    ev_t         exp_q[$];
    logic [31:0] model_q[$];
    logic [31:0] last_rd;

    fifo_ctrl #(.DATA_WIDTH(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .din          (din),
        .dout         (dout),
        .data_count   (data_count),
        .full         (full),
        .empty        (empty),
        .wr_ack       (wr_ack),
        .wr_err       (wr_err),
        .rd_ack       (rd_ack),
        .rd_err       (rd_err)
`ifdef FIFO_CTRL_ALMOST_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Flags and count seen now must match the model holding every request issued so far.
    task automatic check_level();
        int n;
        n = model_q.size();
        check("data_count", 64'(data_count), 64'(n));
        check("full", 64'(full), 64'(n == 8));
        check("empty", 64'(empty), 64'(n == 0));
`ifdef FIFO_CTRL_ALMOST_EN
        check("almost_full", 64'(almost_full), 64'(n == 7));
        check("almost_empty", 64'(almost_empty), 64'(n == 1));
`endif
    endtask

    // One request cycle: drive, let the edge sample it, check, then update the model.
    task automatic step(input logic w, input logic r, input logic [31:0] d);
        ev_t e;
        wr_en = w;
        rd_en = r;
        din   = d;
        @(posedge clk);
        #1;
        check_level();
        if (w && !r) begin
            if (model_q.size() == 8) begin
                e.flags = EV_WERR;
            end else begin
                model_q.push_back(d);
                e.flags = EV_WACK;
            end
            e.dout = last_rd;
            exp_q.push_back(e);
        end else if (r && !w) begin
            if (model_q.size() == 0) begin
                e.flags = EV_RERR;
            end else begin
                last_rd = model_q.pop_front();
                e.flags = EV_RACK;
            end
            e.dout = last_rd;
            exp_q.push_back(e);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_dout"}, 64'(dout), 64'h0);
        check({tag, "_count"}, 64'(data_count), 64'h0);
        check({tag, "_full"}, 64'(full), 64'h0);
        check({tag, "_empty"}, 64'(empty), 64'h1);
        check({tag, "_ackerr"}, 64'({wr_ack, wr_err, rd_ack, rd_err}), 64'h0);
    endtask

    // Monitor: every ack/err cycle consumes one expected event, then dout is checked after the edge.
    initial begin : monitor
        ev_t        e;
        logic [3:0] got;
        forever begin
            @(negedge clk);
            got = {wr_ack, wr_err, rd_ack, rd_err};
            if (reset_n && (got != 4'b0000)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 64'(got), 64'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", 64'(got), 64'(e.flags));
                    @(posedge clk);
                    #1;
                    if (reset_n) begin
                        check("dout", 64'(dout), 64'(e.dout));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int bias;
        tests_run    = 0;
        tests_failed = 0;
        last_rd      = 32'h0;
        reset_n      = 1'b0;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        din          = 32'h0;
        repeat (2) @(posedge clk);
        #3;
        check_reset_values("reset");
        reset_n = 1'b1;

        // Five writes, then reset while the sixth write is in the WRITE state.
        step(1'b1, 1'b0, 32'hA5A5_0001);
        for (int i = 2; i <= 6; i++) begin
            step(1'b1, 1'b0, 32'hA5A5_0000 + 32'(i));
        end
        #2;
        check("write_state_before_reset", 64'(wr_ack), 64'h1);
        check("count5_before_reset", 64'(data_count), 64'h5);
        reset_n = 1'b0;
        exp_q.delete();
        model_q.delete();
        last_rd = 32'h0;
        #1;
        check_reset_values("abort");
        wr_en = 1'b0;
        rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;

        // Next write lands at address 0 and reads back.
        step(1'b1, 1'b0, 32'h1234_5678);
        step(1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 32'h0);

        // Fill with 8, reject a 9th, drain 8 in order, reject one more read.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 32'hC0DE_0000 + 32'(i));
        end
        step(1'b1, 1'b0, 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 32'h0);
        end
        step(1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 32'h0);

        // Simultaneous requests with three entries are ignored.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h3300_0000 + 32'(i));
        end
        step(1'b1, 1'b1, 32'hFFFF_FFFF);
        check("both_no_event", 64'({wr_ack, wr_err, rd_ack, rd_err}), 64'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);

        // Randomized traffic: write-biased, then read-biased, then balanced.
        for (int i = 0; i < 600; i++) begin
            bias = (i < 200) ? 70 : ((i < 400) ? 30 : 50);
            step(($urandom_range(99, 0) < 32'(bias)) ? 1'b1 : 1'b0,
                 ($urandom_range(99, 0) < 32'(100 - bias)) ? 1'b1 : 1'b0,
                 $urandom());
        end

        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 32'h0);
        end
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
